aes_key_schedule: RTL and testbench
===================================

AES_KEY_SCHEDULE -- requirements
Module: aes_key_schedule

Interface
REQ-001 Parameters: none; the block is fixed to AES-128 (Nk=4, Nr=10).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, synchronous and active-low.
REQ-004 start  input  1  request expansion of key_in; sampled only in IDLE.
REQ-005 key_in  input  128  cipher key; byte 0 = key_in[127:120]; word w0 = key_in[127:96].
REQ-006 rk_valid  output  1  rk_data/rk_idx carry a valid round key.
REQ-007 rk_ready  input  1  consumer (round stage) accepts the current key.
REQ-008 rk_data  output  128  round key, same byte order as key_in.
REQ-009 rk_idx  output  4  round number of rk_data, 0..10.
REQ-010 busy  output  1  high in any state other than IDLE.
REQ-011 done  output  1  one-cycle pulse after round key 10 is accepted.

Function
REQ-012 The FSM SHALL have exactly two states: IDLE and EMIT.
REQ-013 IDLE: start=1 SHALL load key_in into the key register, clear the round counter to 0, and enter EMIT on the next edge.
REQ-014 start SHALL be ignored while in EMIT; key_in is sampled only on the accepting edge.
REQ-015 EMIT: rk_valid=1, rk_data=key register, rk_idx=round counter.
REQ-016 Handshake: transfer occurs on an edge where rk_valid && rk_ready; rk_data and rk_idx SHALL hold stable while rk_valid && !rk_ready.
REQ-017 On transfer with round<10: key register <= next_key(key register, Rcon[round+1]); round <= round+1; stay in EMIT.
REQ-018 On transfer with round==10: enter IDLE, assert done for exactly the following cycle, leave key register unchanged.
REQ-019 next_key SHALL be combinational: t = SubWord(RotWord(w3)) ^ {Rcon,24'h0}; w0'=w0^t; w1'=w1^w0'; w2'=w2^w1'; w3'=w3^w2'.
REQ-020 Rcon[1..10] SHALL be 01,02,04,08,10,20,40,80,1B,36 (hex).
REQ-021 Latency: start accepted at edge T -> rk_valid=1 with rk_idx=0 after edge T; with rk_ready held high, keys 0..10 appear on 11 consecutive cycles and done pulses on the 12th.
REQ-022 start asserted in the same cycle as done (already IDLE) SHALL be accepted normally.
REQ-023 The round counter SHALL never exceed 10; values 11..15 are unreachable.
REQ-024 rk_ready while rk_valid=0 SHALL have no effect.

Reset
REQ-025 rst_n=0 at an edge SHALL force IDLE, round=0, key register=0, regardless of state, including mid-expansion.
REQ-026 Reset values: rk_valid=0, rk_data=0, rk_idx=0, busy=0, done=0.
REQ-027 start asserted during reset SHALL be ignored; the first accept is possible on the first edge with rst_n=1.

Structure
REQ-028 Shared package aes_pkg SHALL hold the Rcon table, the S-box table, and the FSM state encoding.
REQ-029 SubWord SHALL be a sub-module aes_subword (32-bit in/out, four S-box lookups), reusing the S-box table also used by aes_subbytes.
REQ-030 The block SHALL contain one 128-bit key register, a 4-bit round counter, one state flop, and one done flop; no other storage.

Verification
REQ-031 FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c, rk_ready=1 -> idx1 a0fafe1788542cb123a339392a6c7605, idx10 d014f9a8c9ee2589e13f0cc8b6630ca6, done one cycle after idx10.
REQ-032 Key all-zero -> idx1 62636363626363636263636362636363, idx10 b4ef5bcb3e92e21123e951cf6f8f188e.
REQ-033 FIPS key, rk_ready toggled pseudo-randomly -> same 11-key sequence, rk_data/rk_idx stable during every stall, no key skipped or repeated.
REQ-034 start pulsed at idx 4 with a different key_in -> ignored, sequence completes with the original key.
REQ-035 rst_n=0 for one edge at idx 6 -> next cycle rk_valid=0, busy=0, all outputs 0; new start restarts at idx 0.
REQ-036 start held high continuously -> back-to-back expansions, new idx 0 appears on the cycle after done.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES definitions: key-schedule FSM encoding, round constants and the
// forward S-box used by both SubWord and SubBytes.
package aes_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } ks_state_e;

  localparam logic [3:0] LAST_ROUND = 4'd10;

  // Entry 0 is unused so that the table is indexed directly by round number
  localparam logic [7:0] RCON [0:10] = '{
    8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  localparam logic [7:0] SBOX [0:255] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[b];
  endfunction

  // Rounds past the last one have no constant; return zero rather than read off the table
  function automatic logic [7:0] rcon(input logic [3:0] round);
    return (round <= LAST_ROUND) ? RCON[round] : 8'h00;
  endfunction

endpackage

// File: rtl/aes_subword.sv
// SubWord: independent S-box substitution of each byte of a 32-bit word.
module aes_subword
  import aes_pkg::*;
(
  input  logic [31:0] word_in,
  output logic [31:0] word_out
);

  assign word_out = {sbox(word_in[31:24]), sbox(word_in[23:16]),
                     sbox(word_in[15:8]),  sbox(word_in[7:0])};

endmodule

// File: rtl/aes_key_schedule.sv
// AES-128 key expansion: emits round keys 0..10 one at a time over a
// valid/ready handshake, deriving each next key on the fly from the current one.
module aes_key_schedule
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [127:0] key_in,
  output logic         rk_valid,
  input  logic         rk_ready,
  output logic [127:0] rk_data,
  output logic [3:0]   rk_idx,
  output logic         busy,
  output logic         done
);

  ks_state_e    state_q, state_d;
  logic [127:0] key_q, key_d;
  logic [3:0]   round_q, round_d;
  logic         done_q, done_d;

  logic [31:0]  w0, w1, w2, w3;
  logic [31:0]  rot_word, sub_word, temp_word;
  logic [31:0]  nw0, nw1, nw2, nw3;
  logic [127:0] next_key;

  assign w0 = key_q[127:96];
  assign w1 = key_q[95:64];
  assign w2 = key_q[63:32];
  assign w3 = key_q[31:0];

  assign rot_word = {w3[23:0], w3[31:24]};

  aes_subword u_subword (
    .word_in  (rot_word),
    .word_out (sub_word)
  );

  // The key being built is for round_q+1, so it takes that round's constant
  assign temp_word = sub_word ^ {rcon(round_q + 4'd1), 24'h000000};
  assign nw0       = w0 ^ temp_word;
  assign nw1       = w1 ^ nw0;
  assign nw2       = w2 ^ nw1;
  assign nw3       = w3 ^ nw2;
  assign next_key  = {nw0, nw1, nw2, nw3};

  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    round_d = round_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          key_d   = key_in;
          round_d = 4'd0;
          state_d = EMIT;
        end
      end
      EMIT: begin
        if (rk_ready) begin
          if (round_q == LAST_ROUND) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            key_d   = next_key;
            round_d = round_q + 4'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      key_q   <= '0;
      round_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      round_q <= round_d;
      done_q  <= done_d;
    end
  end

  assign rk_valid = (state_q == EMIT);
  assign rk_data  = key_q;
  assign rk_idx   = round_q;
  assign busy     = (state_q != IDLE);
  assign done     = done_q;

endmodule

// File: tb/tb_aes_key_schedule.sv
// Self-checking bench for aes_key_schedule: a reference key expansion fills a
// scoreboard on each accepted start, and a monitor pops it on every transfer.
module tb_aes_key_schedule;
  import aes_pkg::*;

  localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] FIPS_R1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] FIPS_R10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] ZERO_KEY = 128'h0;
  localparam logic [127:0] ZERO_R1  = 128'h62636363626363636263636362636363;
  localparam logic [127:0] ZERO_R10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;
  localparam logic [127:0] ALT_KEY  = 128'h000102030405060708090a0b0c0d0e0f;

  typedef struct {
    logic [3:0]   idx;
    logic [127:0] data;
  } sb_entry_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [127:0] key_in;
  logic         rk_valid;
  logic         rk_ready;
  logic [127:0] rk_data;
  logic [3:0]   rk_idx;
  logic         busy;
  logic         done;

  sb_entry_t    sb_q[$];
  int           vectors = 0;
  int           miscompares = 0;
  logic         stall_prev = 1'b0;
  logic         done_pend = 1'b0;
  logic [127:0] prev_data;
  logic [3:0]   prev_idx;

  aes_key_schedule dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .key_in   (key_in),
    .rk_valid (rk_valid),
    .rk_ready (rk_ready),
    .rk_data  (rk_data),
    .rk_idx   (rk_idx),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  // Textbook word-wise expansion; Rcon is generated by repeated doubling in GF(2^8)
  function automatic logic [127:0] ref_key(input logic [127:0] k, input int idx);
    logic [31:0] w [0:43];
    logic [31:0] temp;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      temp = w[i-1];
      if (i % 4 == 0) begin
        temp = {SBOX[temp[23:16]], SBOX[temp[15:8]], SBOX[temp[7:0]], SBOX[temp[31:24]]}
               ^ {rc, 24'h000000};
        rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
      end
      w[i] = w[i-4] ^ temp;
    end
    return {w[4*idx], w[4*idx+1], w[4*idx+2], w[4*idx+3]};
  endfunction

  task automatic check_output(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Known-answer vectors replace the model output where they exist
  task automatic push_expansion(input logic [127:0] k);
    sb_entry_t e;
    for (int i = 0; i <= 10; i++) begin
      e.idx  = 4'(i);
      e.data = ref_key(k, i);
      if (k == FIPS_KEY && i == 1)  e.data = FIPS_R1;
      if (k == FIPS_KEY && i == 10) e.data = FIPS_R10;
      if (k == ZERO_KEY && i == 1)  e.data = ZERO_R1;
      if (k == ZERO_KEY && i == 10) e.data = ZERO_R10;
      sb_q.push_back(e);
    end
  endtask

  task automatic apply_stimulus(input logic [127:0] k);
    start  = 1'b1;
    key_in = k;
    push_expansion(k);
    tick();
    start  = 1'b0;
    key_in = {$urandom, $urandom, $urandom, $urandom};
    @(negedge clk);
    check_output("accept_valid", 128'(rk_valid), 128'(1));
    check_output("accept_idx",   128'(rk_idx),   128'(0));
    check_output("accept_busy",  128'(busy),     128'(1));
  endtask

  task automatic wait_drain(input int budget, input bit random_ready);
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < budget) begin
      if (random_ready) rk_ready = 1'($urandom_range(0, 1));
      tick();
      n++;
    end
    check_output("drain_in_budget", 128'(sb_q.size() == 0), 128'(1));
    sb_q.delete();
    rk_ready = 1'b1;
    tick();
    tick();
    @(negedge clk);
    check_output("idle_busy", 128'(busy), 128'(0));
    tick();
  endtask

  // Monitor: done timing, stall stability and in-order round keys
  always @(negedge clk) begin
    if (!rst_n) begin
      stall_prev = 1'b0;
      done_pend  = 1'b0;
    end else begin
      check_output("done", 128'(done), 128'(done_pend));
      done_pend = 1'b0;
      if (stall_prev) begin
        check_output("stall_data", rk_data, prev_data);
        check_output("stall_idx", 128'(rk_idx), 128'(prev_idx));
      end
      if (rk_valid && rk_ready) begin
        check_output("key_expected", 128'(sb_q.size() != 0), 128'(1));
        if (sb_q.size() != 0) begin
          sb_entry_t e;
          e = sb_q.pop_front();
          check_output($sformatf("rk_idx_%0d", e.idx), 128'(rk_idx), 128'(e.idx));
          check_output($sformatf("rk_data_%0d", e.idx), rk_data, e.data);
          if (e.idx == 4'd10) done_pend = 1'b1;
        end
      end
      stall_prev = rk_valid && !rk_ready;
      prev_data  = rk_data;
      prev_idx   = rk_idx;
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Reset with start held high: nothing may be accepted until rst_n rises
    rst_n    = 1'b0;
    start    = 1'b1;
    key_in   = FIPS_KEY;
    rk_ready = 1'b1;
    tick();
    tick();
    @(negedge clk);
    check_output("rst_valid", 128'(rk_valid), 128'(0));
    check_output("rst_busy",  128'(busy),     128'(0));
    check_output("rst_done",  128'(done),     128'(0));
    check_output("rst_data",  rk_data,        128'(0));
    check_output("rst_idx",   128'(rk_idx),   128'(0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    push_expansion(FIPS_KEY);
    tick();
    start  = 1'b0;
    key_in = ALT_KEY;
    @(negedge clk);
    check_output("first_valid", 128'(rk_valid), 128'(1));
    check_output("first_idx",   128'(rk_idx),   128'(0));
    wait_drain(40, 1'b0);

    // All-zero key
    apply_stimulus(ZERO_KEY);
    wait_drain(40, 1'b0);

    // FIPS key with a randomly stalling consumer
    rk_ready = 1'b0;
    apply_stimulus(FIPS_KEY);
    wait_drain(400, 1'b1);

    // A second start mid-expansion must be ignored
    rk_ready = 1'b1;
    apply_stimulus(FIPS_KEY);
    repeat (3) tick();
    start  = 1'b1;
    key_in = ALT_KEY;
    tick();
    start  = 1'b0;
    wait_drain(40, 1'b0);

    // Reset mid-expansion, then a clean restart
    apply_stimulus(ALT_KEY);
    repeat (5) tick();
    rst_n    = 1'b0;
    rk_ready = 1'b0;
    tick();
    rst_n = 1'b1;
    sb_q.delete();
    @(negedge clk);
    check_output("midrst_valid", 128'(rk_valid), 128'(0));
    check_output("midrst_busy",  128'(busy),     128'(0));
    check_output("midrst_done",  128'(done),     128'(0));
    check_output("midrst_data",  rk_data,        128'(0));
    check_output("midrst_idx",   128'(rk_idx),   128'(0));
    rk_ready = 1'b1;
    apply_stimulus(ALT_KEY);
    wait_drain(40, 1'b0);

    // start held high: second expansion begins the cycle after done
    start  = 1'b1;
    key_in = FIPS_KEY;
    push_expansion(FIPS_KEY);
    tick();
    key_in = ZERO_KEY;
    push_expansion(ZERO_KEY);
    repeat (11) tick();
    @(negedge clk);
    check_output("b2b_done",  128'(done),     128'(1));
    check_output("b2b_gap",   128'(rk_valid), 128'(0));
    tick();
    start = 1'b0;
    @(negedge clk);
    check_output("b2b_valid", 128'(rk_valid), 128'(1));
    check_output("b2b_idx",   128'(rk_idx),   128'(0));
    wait_drain(40, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
